// File: rtl/ip_vdp9918_vram_ctrl_if.sv
// VDP VRAM request bus: CPU-side request/response, display fetch and the single-port VRAM pins.
// The controller takes the slave view; initiators and the memory model take the master view.
interface ip_vdp9918_vram_ctrl_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [13:0] cpu_address;
    logic [7:0]  cpu_write_data;
    logic        cpu_busy;
    logic        cpu_read_ready;
    logic [7:0]  cpu_read_data;
    logic        disp_request;
    logic [13:0] disp_address;
    logic        disp_ready;
    logic [7:0]  disp_data;
    logic [13:0] mem_address;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_write_data,
        output cpu_busy, cpu_read_ready, cpu_read_data,
        input  disp_request, disp_address,
        output disp_ready, disp_data,
        output mem_address, mem_oe, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_write_data,
        input  cpu_busy, cpu_read_ready, cpu_read_data,
        output disp_request, disp_address,
        input  disp_ready, disp_data,
        input  mem_address, mem_oe, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/ip_vdp9918_vram_ctrl.sv
// VDP VRAM controller: arbitrates edge-captured CPU requests against display fetches onto one
// single-port VRAM with fixed read latency, one access outstanding at a time.
module ip_vdp9918_vram_ctrl #(
    parameter int unsigned MEM_LATENCY = 2
) (
    input logic                   clk,
    input logic                   reset,
    ip_vdp9918_vram_ctrl_if.slave bus
);
    localparam logic [2:0] LatLast = 3'(MEM_LATENCY);

    typedef enum logic [1:0] {StIdle, StAccess, StResult} state_e;

    state_e      state;
    logic        req_prev;
    logic        slot_valid;
    logic        slot_write;
    logic [13:0] slot_address;
    logic [7:0]  slot_wdata;
    logic        last_disp;
    logic        serve_disp;
    logic [2:0]  lat_cnt;

    logic        cpu_req;
    logic        capture;
    logic        write_done;
    logic        cpu_pending;
    logic        pick_disp;
    logic        pick_cpu;
    logic        sel_write;
    logic [13:0] sel_address;
    logic [7:0]  sel_wdata;

    assign cpu_req     = bus.cpu_read | bus.cpu_write;
    assign capture     = cpu_req & ~req_prev & ~slot_valid;
    // mem_we is high in the cycle after a write issue; that slot is finishing, not pending.
    assign write_done  = (state == StIdle) & bus.mem_we;
    assign cpu_pending = capture | (slot_valid & ~write_done);
    assign pick_disp   = bus.disp_request & (~cpu_pending | ~last_disp);
    assign pick_cpu    = cpu_pending & ~pick_disp;
    assign sel_write   = slot_valid ? slot_write : bus.cpu_write;
    assign sel_address = slot_valid ? slot_address : bus.cpu_address;
    assign sel_wdata   = slot_valid ? slot_wdata : bus.cpu_write_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= StIdle;
            req_prev           <= 1'b0;
            slot_valid         <= 1'b0;
            slot_write         <= 1'b0;
            slot_address       <= '0;
            slot_wdata         <= '0;
            last_disp          <= 1'b0;
            serve_disp         <= 1'b0;
            lat_cnt            <= '0;
            bus.cpu_busy       <= 1'b0;
            bus.cpu_read_ready <= 1'b0;
            bus.cpu_read_data  <= '0;
            bus.disp_ready     <= 1'b0;
            bus.disp_data      <= '0;
            bus.mem_address    <= '0;
            bus.mem_oe         <= 1'b0;
            bus.mem_we         <= 1'b0;
            bus.mem_wdata      <= '0;
        end else begin
            req_prev           <= cpu_req;
            bus.mem_oe         <= 1'b0;
            bus.mem_we         <= 1'b0;
            bus.cpu_read_ready <= 1'b0;
            bus.disp_ready     <= 1'b0;

            if (capture) begin
                slot_valid   <= 1'b1;
                slot_write   <= bus.cpu_write;
                slot_address <= bus.cpu_address;
                slot_wdata   <= bus.cpu_write_data;
                bus.cpu_busy <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (write_done) begin
                        slot_valid   <= 1'b0;
                        bus.cpu_busy <= 1'b0;
                    end
                    if (pick_disp) begin
                        bus.mem_address <= bus.disp_address;
                        bus.mem_oe      <= 1'b1;
                        serve_disp      <= 1'b1;
                        last_disp       <= 1'b1;
                        lat_cnt         <= '0;
                        state           <= StAccess;
                    end else if (pick_cpu) begin
                        bus.mem_address <= sel_address;
                        serve_disp      <= 1'b0;
                        last_disp       <= 1'b0;
                        if (sel_write) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_wdata <= sel_wdata;
                        end else begin
                            bus.mem_oe <= 1'b1;
                            lat_cnt    <= '0;
                            state      <= StAccess;
                        end
                    end
                end
                StAccess: begin
                    // lat_cnt reaches MEM_LATENCY exactly when mem_rdata is valid.
                    if (lat_cnt == LatLast) begin
                        state <= StResult;
                        if (serve_disp) begin
                            bus.disp_ready <= 1'b1;
                            bus.disp_data  <= bus.mem_rdata;
                        end else begin
                            bus.cpu_read_ready <= 1'b1;
                            bus.cpu_read_data  <= bus.mem_rdata;
                            slot_valid         <= 1'b0;
                            bus.cpu_busy       <= 1'b0;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                StResult: state <= StIdle;
                default:  state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_ip_vdp9918_vram_ctrl.sv
// Bench for the VDP VRAM controller: directed and randomized transactions checked against a
// transaction-level timing/data model; two extra instances check MEM_LATENCY=1 and 7.
module tb_ip_vdp9918_vram_ctrl;
    localparam int Lat = 2;
    localparam int Win = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tb_init = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    ip_vdp9918_vram_ctrl_if bus ();
    ip_vdp9918_vram_ctrl_if bus1 ();
    ip_vdp9918_vram_ctrl_if bus7 ();

    ip_vdp9918_vram_ctrl #(.MEM_LATENCY(Lat)) dut (.clk(clk), .reset(reset), .bus(bus));
    ip_vdp9918_vram_ctrl #(.MEM_LATENCY(1)) dut_l1 (.clk(clk), .reset(reset), .bus(bus1));
    ip_vdp9918_vram_ctrl #(.MEM_LATENCY(7)) dut_l7 (.clk(clk), .reset(reset), .bus(bus7));

    assign bus1.cpu_read       = bus.cpu_read;
    assign bus1.cpu_write      = bus.cpu_write;
    assign bus1.cpu_address    = bus.cpu_address;
    assign bus1.cpu_write_data = bus.cpu_write_data;
    assign bus1.disp_request   = bus.disp_request;
    assign bus1.disp_address   = bus.disp_address;
    assign bus1.mem_rdata      = 8'h3C;
    assign bus7.cpu_read       = bus.cpu_read;
    assign bus7.cpu_write      = bus.cpu_write;
    assign bus7.cpu_address    = bus.cpu_address;
    assign bus7.cpu_write_data = bus.cpu_write_data;
    assign bus7.disp_request   = bus.disp_request;
    assign bus7.disp_address   = bus.disp_address;
    assign bus7.mem_rdata      = 8'h3C;

    // VRAM model: data appears Lat cycles after the mem_oe cycle, junk otherwise.
    logic [7:0]  vram [16384];
    logic [7:0]  ref_mem [16384];
    logic [7:0]  oe_hist = '0;
    logic [13:0] addr_hist [8];
    logic [7:0]  junk = '0;

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 37 + 11);
    endfunction

    always @(posedge clk) begin
        oe_hist      <= {oe_hist[6:0], bus.mem_oe};
        addr_hist[0] <= bus.mem_address;
        for (int i = 1; i < 8; i++) addr_hist[i] <= addr_hist[i-1];
        junk <= 8'($urandom);
        if (tb_init) begin
            for (int i = 0; i < 16384; i++) vram[i] <= init_val(i);
        end else if (bus.mem_we) begin
            vram[bus.mem_address] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = oe_hist[Lat-1] ? vram[addr_hist[Lat-1]] : junk;

    // Model state carried between transactions.
    bit         m_last_disp = 1'b0;
    logic [7:0] m_cpu_rd = '0;
    logic [7:0] m_disp_rd = '0;
    int         r1_k;
    int         r7_k;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic run_txn(input bit do_cpu, input bit cpu_wr, input logic [13:0] ca,
                           input logic [7:0] cd, input bit do_disp, input logic [13:0] da,
                           input bit cpu_hold, input bit glitch);
        bit          ord_disp [2];
        int          ord_n;
        int          exp_k [2];
        int          exp_done [2];
        int          ci;
        int          nk;
        logic [7:0]  exp_cpu_rd;
        logic [7:0]  exp_disp_rd;
        int          st_k [4];
        bit          st_we [4];
        logic [13:0] st_addr [4];
        logic [7:0]  st_wd [4];
        int          n_st;
        int          busy_rise;
        int          busy_fall;
        int          rdy_k;
        int          n_rdy;
        int          dr_k;
        int          n_dr;
        logic [7:0]  rdy_data;
        logic [7:0]  dr_data;

        // Service order: a tie goes to whichever kind was not serviced last.
        if (do_cpu && do_disp) begin
            ord_disp[0] = !m_last_disp;
            ord_disp[1] = m_last_disp;
            ord_n = 2;
        end else begin
            ord_disp[0] = do_disp;
            ord_disp[1] = 1'b0;
            ord_n = 1;
        end
        exp_cpu_rd  = m_cpu_rd;
        exp_disp_rd = m_disp_rd;
        ci = 0;
        nk = 1;
        for (int i = 0; i < ord_n; i++) begin
            exp_k[i] = nk;
            if (!ord_disp[i]) ci = i;
            if (!ord_disp[i] && cpu_wr) begin
                exp_done[i] = nk + 1;
                nk = nk + 1;
                ref_mem[ca] = cd;
            end else begin
                exp_done[i] = nk + Lat + 1;
                nk = exp_done[i] + 2;
                if (ord_disp[i]) exp_disp_rd = ref_mem[da];
                else exp_cpu_rd = ref_mem[ca];
            end
        end
        m_last_disp = ord_disp[ord_n-1];

        for (int i = 0; i < 4; i++) begin
            st_k[i] = -1; st_we[i] = 1'b0; st_addr[i] = '0; st_wd[i] = '0;
        end
        n_st = 0; busy_rise = -1; busy_fall = -1; rdy_k = -1; n_rdy = 0; dr_k = -1; n_dr = 0;
        rdy_data = '0; dr_data = '0; r1_k = -1; r7_k = -1;

        @(posedge clk); #1;
        bus.cpu_address    = ca;
        bus.cpu_write_data = cd;
        bus.disp_address   = da;
        bus.cpu_write      = do_cpu && cpu_wr;
        bus.cpu_read       = do_cpu && (!cpu_wr || $urandom_range(0, 1) == 1);
        bus.disp_request   = do_disp;
        for (int k = 0; k < Win; k++) begin
            @(negedge clk);
            if (bus.mem_oe || bus.mem_we) begin
                if (n_st < 4) begin
                    st_k[n_st] = k; st_we[n_st] = bus.mem_we;
                    st_addr[n_st] = bus.mem_address; st_wd[n_st] = bus.mem_wdata;
                end
                n_st++;
            end
            if (bus.cpu_busy && busy_rise < 0) busy_rise = k;
            if (!bus.cpu_busy && busy_rise >= 0 && busy_fall < 0) busy_fall = k;
            if (bus.cpu_read_ready) begin
                n_rdy++;
                if (rdy_k < 0) begin rdy_k = k; rdy_data = bus.cpu_read_data; end
            end
            if (bus.disp_ready) begin
                n_dr++;
                if (dr_k < 0) begin dr_k = k; dr_data = bus.disp_data; end
            end
            if (bus1.cpu_read_ready && r1_k < 0) r1_k = k;
            if (bus7.cpu_read_ready && r7_k < 0) r7_k = k;
            @(posedge clk); #1;
            bus.cpu_address    = 14'($urandom);
            bus.cpu_write_data = 8'($urandom);
            if (!cpu_hold || busy_fall >= 0) begin
                bus.cpu_read  = 1'b0;
                bus.cpu_write = 1'b0;
            end
            if (glitch) bus.cpu_read = (k == 1);
            if (dr_k >= 0) bus.disp_request = 1'b0;
        end
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.disp_request = 1'b0;

        check("strobe_count", n_st, ord_n);
        for (int i = 0; i < ord_n; i++) begin
            check("strobe_cycle", st_k[i], exp_k[i]);
            check("strobe_is_write", st_we[i], !ord_disp[i] && cpu_wr);
            check("strobe_address", st_addr[i], ord_disp[i] ? da : ca);
            if (!ord_disp[i] && cpu_wr) check("write_data", st_wd[i], cd);
        end
        if (do_cpu) begin
            check("busy_rise", busy_rise, 1);
            check("busy_fall", busy_fall, exp_done[ci]);
        end else begin
            check("busy_idle", busy_rise, -1);
        end
        check("cpu_ready_count", n_rdy, (do_cpu && !cpu_wr) ? 1 : 0);
        if (do_cpu && !cpu_wr) begin
            check("cpu_ready_cycle", rdy_k, exp_done[ci]);
            check("cpu_read_data", rdy_data, exp_cpu_rd);
        end
        check("disp_ready_count", n_dr, do_disp ? 1 : 0);
        if (do_disp) begin
            check("disp_ready_cycle", dr_k, exp_done[ord_disp[0] ? 0 : 1]);
            check("disp_data", dr_data, exp_disp_rd);
        end
        check("cpu_read_data_held", bus.cpu_read_data, exp_cpu_rd);
        check("disp_data_held", bus.disp_data, exp_disp_rd);
        m_cpu_rd  = exp_cpu_rd;
        m_disp_rd = exp_disp_rd;
    endtask

    task automatic reset_mid();
        int n_rdy;
        n_rdy = 0;
        @(posedge clk); #1;
        bus.cpu_address = 14'($urandom);
        bus.cpu_read    = 1'b1;
        @(posedge clk); #1;
        bus.cpu_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_busy", bus.cpu_busy, 0);
        check("mid_reset_strobes", {bus.mem_oe, bus.mem_we, bus.cpu_read_ready, bus.disp_ready}, 0);
        check("mid_reset_data", {bus.cpu_read_data, bus.disp_data}, 0);
        for (int i = 0; i < Win; i++) begin
            @(negedge clk);
            if (bus.cpu_read_ready) n_rdy++;
        end
        check("mid_reset_no_ready", n_rdy, 0);
        m_last_disp = 1'b0;
        m_cpu_rd    = '0;
        m_disp_rd   = '0;
    endtask

    initial begin
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_address = '0; bus.cpu_write_data = '0;
        bus.disp_request = 1'b0; bus.disp_address = '0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = init_val(i);
        tb_init = 1'b1;
        repeat (3) @(posedge clk);
        #1 tb_init = 1'b0;
        @(negedge clk);
        check("reset_strobes", {bus.mem_oe, bus.mem_we, bus.cpu_read_ready, bus.disp_ready,
                                bus.cpu_busy}, 0);
        check("reset_mem_bus", {bus.mem_address, bus.mem_wdata}, 0);
        check("reset_data", {bus.cpu_read_data, bus.disp_data}, 0);
        @(posedge clk); #1 reset = 1'b0;

        run_txn(1'b1, 1'b1, 14'h1234, 8'hA5, 1'b0, 14'h0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b1, 14'h3FFF, 8'h5A, 1'b0, 14'h0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 14'h3FFF, 8'h00, 1'b0, 14'h0, 1'b0, 1'b0);
        check("latency1_ready_cycle", r1_k, 3);
        check("latency7_ready_cycle", r7_k, 9);
        check("latency7_data", bus7.cpu_read_data, 8'h3C);

        run_txn(1'b1, 1'b0, 14'h0200, 8'h00, 1'b1, 14'h0100, 1'b0, 1'b0);
        run_txn(1'b0, 1'b0, 14'h0000, 8'h00, 1'b1, 14'h0155, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 14'h0200, 8'h00, 1'b1, 14'h0100, 1'b1, 1'b0);
        run_txn(1'b1, 1'b0, 14'h2AAA, 8'h00, 1'b0, 14'h0, 1'b0, 1'b1);
        run_txn(1'b1, 1'b1, 14'h0200, 8'hC3, 1'b1, 14'h0200, 1'b1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            bit          dc;
            bit          dd;
            bit          wr;
            bit          hold;
            bit          gl;
            logic [13:0] ca;
            logic [13:0] da;
            dc   = $urandom_range(0, 1) == 1;
            dd   = $urandom_range(0, 1) == 1;
            if (!dc && !dd) dc = 1'b1;
            wr   = $urandom_range(0, 1) == 1;
            hold = $urandom_range(0, 1) == 1;
            gl   = dc && !wr && !hold && ($urandom_range(0, 2) == 0);
            // Small address window so reads often land on earlier writes.
            ca   = 14'($urandom_range(0, 31));
            da   = 14'($urandom_range(0, 31));
            run_txn(dc, wr, ca, 8'($urandom), dd, da, hold, gl);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        reset_mid();
        run_txn(1'b1, 1'b0, 14'h1234, 8'h00, 1'b1, 14'h3FFF, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
